// File: rtl/pc_mul_pkg.sv
// Shared types and helpers for the PC node multiplier result path.
//
// Contents:
//   NLANES      number of product lanes coming out of the multiplier tree
//   LANE_W      default lane width (bf16)
//   lane_t      one lane of product data
//   coll_state_e  collector FSM states
//   mode2mask() lane configuration -> mask of lanes expected to produce a product
package pc_mul_pkg;

    localparam int NLANES = 4;
    localparam int LANE_W = 16;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic {
        IDLE,
        COLLECT
    } coll_state_e;

    // Same encoding as the tree: 00 and 11 both mean all four lanes are live.
    function automatic logic [NLANES-1:0] mode2mask(input logic [1:0] mode);
        case (mode)
            2'b01:   mode2mask = 4'b0101;
            2'b10:   mode2mask = 4'b0001;
            default: mode2mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/pc_sync_fifo.sv
// Small synchronous FIFO with registered storage and no write-to-read bypass.
//
// Ports:
//   clk        clock, posedge
//   rst        asynchronous active-low reset, empties the FIFO
//   push       write push_data at the tail (ignored when full unless popping)
//   push_data  word to write
//   pop        remove the head word (ignored when empty)
//   head_data  word at the head, zero while empty
//   full       DEPTH entries held
//   empty      no entries held
//   count      number of entries held
module pc_sync_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mul_tree_result_collector.sv
// Collects skewed per-lane products from mul_tree_bf16 into aligned 4-lane
// result words and buffers them in a small FIFO drained by valid/ready.
//
// Ports:
//   clk        clock, posedge
//   rst        asynchronous active-low reset
//   mode       lane configuration (00/11 all lanes, 01 lanes 0 and 2, 10 lane 0)
//   lane_data  tree outputs, lane k at [k*DW +: DW]
//   lane_stb   per-lane product strobes
//   res_data   head result word, lanes outside res_mask are zero
//   res_mask   lanes that contributed to res_data
//   res_valid  a result word is available
//   res_ready  consumer takes the head word when res_valid is high
//   err_ovf    sticky: a completed result was dropped because the FIFO was full
//   err_skew   sticky: a lane re-strobed mid-result or the skew window expired
//   drop_cnt   saturating count of dropped and aborted results
module mul_tree_result_collector
    import pc_mul_pkg::*;
#(
    parameter int DW       = LANE_W,
    parameter int DEPTH    = 4,
    parameter int SKEW_MAX = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [NLANES*DW-1:0]   lane_data,
    input  logic [NLANES-1:0]      lane_stb,
    output logic [NLANES*DW-1:0]   res_data,
    output logic [NLANES-1:0]      res_mask,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   err_ovf,
    output logic                   err_skew,
    output logic [7:0]             drop_cnt
);

    localparam int SW = $clog2(SKEW_MAX + 1);
    localparam int WW = NLANES * DW + NLANES;

    coll_state_e                  state_q, state_d;
    logic [NLANES-1:0]            exp_q, exp_d;
    logic [NLANES-1:0]            seen_q, seen_d;
    logic [NLANES-1:0][DW-1:0]    staging_q, staging_d;
    logic [SW-1:0]                skew_q, skew_d;
    logic                         err_ovf_q, err_ovf_d;
    logic                         err_skew_q, err_skew_d;
    logic [7:0]                   drop_q, drop_d;

    logic [NLANES-1:0]            mask_now;
    logic [NLANES-1:0]            stb_e;
    logic                         commit, abort, ovf_drop, pop;
    logic [NLANES*DW-1:0]         commit_data;
    logic [WW-1:0]                head_word;
    logic                         fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]       fifo_count;
    logic [1:0]                   drop_inc;
    logic [8:0]                   drop_sum;

    assign mask_now = mode2mask(mode);

    // Collector FSM. The expected-lane mask is frozen when a result starts so a
    // mode change mid-collect cannot corrupt it. skew_q counts cycles since the
    // first strobe minus one, so skew_q+1 is the age of the result this cycle.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        seen_d    = seen_q;
        staging_d = staging_q;
        skew_d    = skew_q;
        stb_e     = '0;
        commit    = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                stb_e = lane_stb & mask_now;
                if (stb_e != '0) begin
                    exp_d  = mask_now;
                    seen_d = stb_e;
                    skew_d = '0;
                    if (stb_e == mask_now) begin
                        commit = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                stb_e = lane_stb & exp_q;
                if ((stb_e & seen_q) != '0) begin
                    // A repeated lane means the old result is broken; the new
                    // strobes begin the next result.
                    abort  = 1'b1;
                    seen_d = stb_e;
                    skew_d = '0;
                    if (stb_e == exp_q) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end else if ((seen_q | stb_e) == exp_q) begin
                    commit  = 1'b1;
                    seen_d  = seen_q | stb_e;
                    state_d = IDLE;
                end else if (skew_q == SW'(SKEW_MAX - 1)) begin
                    abort   = 1'b1;
                    seen_d  = '0;
                    state_d = IDLE;
                end else begin
                    seen_d = seen_q | stb_e;
                    skew_d = skew_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        for (int k = 0; k < NLANES; k++) begin
            if (stb_e[k]) begin
                staging_d[k] = lane_data[k*DW +: DW];
            end
        end
    end

    // Result word as written to the FIFO: lanes outside the expected mask are zeroed.
    always_comb begin
        commit_data = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (exp_d[k]) begin
                commit_data[k*DW +: DW] = staging_d[k];
            end
        end
    end

    assign pop      = res_ready & ~fifo_empty;
    assign ovf_drop = commit & fifo_full & ~pop;

    // An abort and an overflowed commit can coincide on a re-strobe that also
    // completes a result, so the drop counter may advance by two.
    always_comb begin
        err_ovf_d  = err_ovf_q | ovf_drop;
        err_skew_d = err_skew_q | abort;
        drop_inc   = 2'(abort) + 2'(ovf_drop);
        drop_sum   = {1'b0, drop_q} + {7'b0, drop_inc};
        drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            seen_q     <= '0;
            staging_q  <= '0;
            skew_q     <= '0;
            err_ovf_q  <= 1'b0;
            err_skew_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            seen_q     <= seen_d;
            staging_q  <= staging_d;
            skew_q     <= skew_d;
            err_ovf_q  <= err_ovf_d;
            err_skew_q <= err_skew_d;
            drop_q     <= drop_d;
        end
    end

    pc_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (commit & ~ovf_drop),
        .push_data ({commit_data, exp_d}),
        .pop       (pop),
        .head_data (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign res_data  = head_word[WW-1:NLANES];
    assign res_mask  = head_word[NLANES-1:0];
    assign res_valid = (fifo_count != '0);
    assign err_ovf   = err_ovf_q;
    assign err_skew  = err_skew_q;
    assign drop_cnt  = drop_q;

endmodule
